// File: rtl/mem_bus_unit_pkg.sv
// Shared encodings and default timing constants for the memory bus unit.
package mem_bus_pkg;

    localparam logic [1:0] S_IDLE   = 2'b00;
    localparam logic [1:0] S_ACCESS = 2'b01;
    localparam logic [1:0] S_RESP   = 2'b10;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_DU = 1'b1
    } owner_t;

    localparam int DEF_WAIT_STATES = 1;
    localparam int DEF_TIMEOUT     = 64;
    localparam int DEF_STARVE_MAX  = 4;

endpackage

// File: rtl/mem_bus_unit_if.sv
// Prefetch, data-port and external memory signals of the bus unit.
interface mem_bus_unit_if;
    logic        if_req;
    logic [19:0] if_adr;
    logic        if_ack;
    logic [15:0] if_dat;

    logic        du_req;
    logic        du_we;
    logic [1:0]  du_be;
    logic [19:0] du_adr;
    logic [15:0] du_wdat;
    logic        du_ack;
    logic [15:0] du_rdat;
    logic        du_err;

    logic        mem_cs;
    logic        mem_we;
    logic [1:0]  mem_be;
    logic [19:0] mem_adr;
    logic [15:0] mem_wdat;
    logic [15:0] mem_rdat;
    logic        mem_rdy;

    modport slave (
        input  if_req, if_adr, du_req, du_we, du_be, du_adr, du_wdat, mem_rdat, mem_rdy,
        output if_ack, if_dat, du_ack, du_rdat, du_err,
               mem_cs, mem_we, mem_be, mem_adr, mem_wdat
    );

    modport master (
        output if_req, if_adr, du_req, du_we, du_be, du_adr, du_wdat, mem_rdat, mem_rdy,
        input  if_ack, if_dat, du_ack, du_rdat, du_err,
               mem_cs, mem_we, mem_be, mem_adr, mem_wdat
    );
endinterface

// File: rtl/mem_bus_unit_arb.sv
// Fetch/data arbiter: data normally wins, but a fetch pending through
// STARVE_MAX back-to-back data grants takes the next one.
module mem_bus_arb
    import mem_bus_pkg::*;
#(
    parameter int STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   i_if_req,
    input  logic   i_du_req,
    input  logic   i_grant,
    output owner_t o_owner
);
    localparam int SW = $clog2(STARVE_MAX + 2);

    logic [SW-1:0] r_starve;
    logic          w_starved;

    assign w_starved = i_if_req && (r_starve == SW'(STARVE_MAX));
    assign o_owner   = (i_du_req && !w_starved) ? OWN_DU : OWN_IF;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
        end else if (i_grant) begin
            if (o_owner == OWN_DU && i_if_req) begin
                if (r_starve != SW'(STARVE_MAX))
                    r_starve <= r_starve + SW'(1);
            end else begin
                r_starve <= '0;
            end
        end
    end
endmodule

// File: rtl/mem_bus_unit.sv
// Single-outstanding bus unit sharing one 16-bit memory port between the
// prefetcher and the execute unit, with wait states, ready and timeout.
module mem_bus_unit
    import mem_bus_pkg::*;
#(
    parameter int WAIT_STATES = DEF_WAIT_STATES,
    parameter int TIMEOUT     = DEF_TIMEOUT,
    parameter int STARVE_MAX  = DEF_STARVE_MAX
) (
    input  logic         clk,
    input  logic         rst,
    mem_bus_unit_if.slave bus
);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [1:0]    r_state;
    owner_t        r_owner;
    owner_t        w_owner;
    logic          r_we;
    logic [1:0]    r_be;
    logic [19:0]   r_adr;
    logic [15:0]   r_wdat;
    logic [15:0]   r_if_dat;
    logic [15:0]   r_du_rdat;
    logic [3:0]    r_wcnt;
    logic [TW-1:0] r_tcnt;
    logic          r_err;
    logic          w_grant;
    logic          w_done;
    logic          w_tout;
    logic          w_access;
    logic          w_resp;

    assign w_grant  = (r_state == S_IDLE) && (bus.if_req || bus.du_req);
    assign w_done   = (r_wcnt == 4'd0) && bus.mem_rdy;
    assign w_tout   = (r_tcnt == TW'(TIMEOUT - 1));
    assign w_access = (r_state == S_ACCESS);
    assign w_resp   = (r_state == S_RESP);

    mem_bus_arb #(.STARVE_MAX(STARVE_MAX)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .i_if_req (bus.if_req),
        .i_du_req (bus.du_req),
        .i_grant  (w_grant),
        .o_owner  (w_owner)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_owner   <= OWN_IF;
            r_we      <= 1'b0;
            r_be      <= 2'b00;
            r_adr     <= '0;
            r_wdat    <= '0;
            r_if_dat  <= '0;
            r_du_rdat <= '0;
            r_wcnt    <= '0;
            r_tcnt    <= '0;
            r_err     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_owner <= w_owner;
                        if (w_owner == OWN_DU) begin
                            r_we   <= bus.du_we;
                            r_be   <= bus.du_be;
                            r_adr  <= bus.du_adr;
                            r_wdat <= bus.du_wdat;
                        end else begin
                            r_we   <= 1'b0;
                            r_be   <= 2'b11;
                            r_adr  <= bus.if_adr;
                            r_wdat <= '0;
                        end
                        r_wcnt  <= 4'(WAIT_STATES);
                        r_tcnt  <= '0;
                        r_err   <= 1'b0;
                        r_state <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (r_wcnt != 4'd0)
                        r_wcnt <= r_wcnt - 4'd1;
                    // Ready wins over timeout when both land in the same cycle.
                    if (w_done) begin
                        if (r_owner == OWN_IF)
                            r_if_dat <= bus.mem_rdat;
                        else if (!r_we)
                            r_du_rdat <= bus.mem_rdat;
                        r_state <= S_RESP;
                    end else if (w_tout) begin
                        r_err <= 1'b1;
                        if (r_owner == OWN_IF)
                            r_if_dat <= '0;
                        else
                            r_du_rdat <= '0;
                        r_state <= S_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + TW'(1);
                    end
                end
                S_RESP:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.mem_cs   = w_access;
    assign bus.mem_we   = w_access && r_we;
    assign bus.mem_be   = w_access ? r_be   : 2'b00;
    assign bus.mem_adr  = w_access ? r_adr  : 20'h0;
    assign bus.mem_wdat = w_access ? r_wdat : 16'h0;

    assign bus.if_ack  = w_resp && (r_owner == OWN_IF);
    assign bus.du_ack  = w_resp && (r_owner == OWN_DU);
    assign bus.du_err  = bus.du_ack && r_err;
    assign bus.if_dat  = r_if_dat;
    assign bus.du_rdat = r_du_rdat;
endmodule
